decoder_f_scan_ctrl: RTL
========================

// Module: decoder_f_scan_ctrl
// PURPOSE
//  Self-test sequencer for the 3-bit-select function decoder (decoder_f).
//  On start, it steps the select s through codes 0..7 and holds each for a programmable dwell.
//  It samples f1/f2/f3 at the end of each dwell, builds 8-bit truth maps and compares them to
//  expected masks. It sits beside decoder_f and owns its select input during a scan.
// PARAMETERS
//  DWELL   4          cycles each code is held; legal 1..255; sample on last dwell cycle
//  EXP_F1  8'h00      expected f1 truth map; bit i = f1 when s==i
//  EXP_F2  8'h00      expected f2 truth map
//  EXP_F3  8'h00      expected f3 truth map
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  begin scan; sampled in IDLE or DONE only, ignored while busy
//  s          out  3  select driven to decoder_f.s
//  f1         in   1  decoder_f output f1
//  f2         in   1  decoder_f output f2
//  f3         in   1  decoder_f output f3
//  busy       out  1  high while scanning
//  done       out  1  high from scan completion until next start or rst
//  pass       out  1  valid when done; 1 = all three maps equal expected
//  fail_code  out  3  lowest s with any f mismatch; 0 when pass
//  f1_map     out  8  captured f1 map; f2_map/f3_map (out, 8) identical for f2/f3
// BEHAVIOUR
//  Reset: state=IDLE; s=0; busy=0; done=0; pass=0; fail_code=0; maps=0; dwell count=0.
//  FSM states: IDLE, RUN, DONE. All outputs are registered.
//   IDLE: start=1 -> RUN; s=0, dwell cnt=0, maps cleared, busy=1.
//   RUN:  cnt increments each cycle.
//         When cnt==DWELL-1: map[s] <= f (all three); cnt <= 0.
//           If s==7 -> DONE, busy=0, done=1, with pass/fail_code from completed maps.
//           Else s <= s+1.
//   DONE: s holds at 7, maps and result hold. start=1 -> RUN as from IDLE; done cleared on the same edge.
//  Latency: start seen at edge T -> busy=1 after T. Code k is driven for cycles
//   k*DWELL..(k+1)*DWELL-1 after T. done=1 and busy=0 after edge T+8*DWELL.
//  Sampling: f is captured in the last dwell cycle, so decoder_f has DWELL-1 cycles of settling.
//   With DWELL=1, capture occurs in the same cycle s changes (combinational decoder).
//  pass = (f1_map==EXP_F1)&&(f2_map==EXP_F2)&&(f3_map==EXP_F3), including the final sample.
//  fail_code = lowest i with any map bit i != expected bit i; priority from bit 0.
//  s never wraps: 7 is terminal, and there is no increment past 7.
//  busy and done are never high together.
//  start held high through a scan has no effect. If start is still high in DONE, it restarts on the next edge.
//  rst in any state, including mid-RUN, returns all state to reset values on that edge; rst wins over start.
//  The dwell counter is 8 bits wide. DWELL outside 1..255 is unsupported and flagged by an elaboration check.
// TESTING
//  T1 reset: rst=1 for 2 cycles with start=1 -> s=0, busy=0, done=0, pass=0, maps=0.
//  T2 golden: decoder_f model f1=s==3, f2=s[0], f3=&s; EXP_F1=8'h08, EXP_F2=8'hAA, EXP_F3=8'h80;
//     DWELL=4, pulse start -> busy for 32 cycles, done=1, pass=1, fail_code=0, maps equal EXP.
//  T3 fault: force f2=0 when s==5 -> f2_map=8'h8A, pass=0, fail_code=5;
//     a second fault at s=6 still gives fail_code=5.
//  T4 timing: DWELL=1 -> done exactly 8 cycles after the start edge;
//     s sequence 0,1,..,7 observed one per cycle.
//  T5 mid-scan reset and restart: rst at s=3 -> IDLE, s=0.
//     Then a start pulse while busy is ignored (busy stays high, scan not restarted).
//     A start in DONE reruns the scan, with maps cleared on the first RUN cycle.

Source files
------------

// File: rtl/decoder_f_scan_ctrl.sv
// ============================================================================
// Module      : decoder_f_scan_ctrl
// Description : Self-test sequencer that sweeps decoder_f select codes 0..7,
//               captures f1/f2/f3 truth maps and compares them to masks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_f_scan_ctrl #(
    parameter int unsigned DWELL  = 4,
    parameter logic [7:0]  EXP_F1 = 8'h00,
    parameter logic [7:0]  EXP_F2 = 8'h00,
    parameter logic [7:0]  EXP_F3 = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] s,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_code,
    output logic [7:0] f1_map,
    output logic [7:0] f2_map,
    output logic [7:0] f3_map
);

    generate
        if (DWELL < 1 || DWELL > 255) begin : g_dwell_check
            $error("decoder_f_scan_ctrl: DWELL must be within 1..255");
        end
    endgenerate

    localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] f1_map_q, f1_map_d;
    logic [7:0] f2_map_q, f2_map_d;
    logic [7:0] f3_map_q, f3_map_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] fail_code_q, fail_code_d;

    // Maps as they will look once the current code's sample is folded in
    logic [7:0] f1_cap, f2_cap, f3_cap;
    logic [7:0] map_diff;
    logic [2:0] first_bad;

    always_comb begin
        f1_cap        = f1_map_q;
        f2_cap        = f2_map_q;
        f3_cap        = f3_map_q;
        f1_cap[s_q]   = f1;
        f2_cap[s_q]   = f2;
        f3_cap[s_q]   = f3;
        map_diff      = (f1_cap ^ EXP_F1) | (f2_cap ^ EXP_F2) | (f3_cap ^ EXP_F3);
        first_bad     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (map_diff[i]) begin
                first_bad = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        f1_map_d    = f1_map_q;
        f2_map_d    = f2_map_q;
        f3_map_d    = f3_map_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    s_d         = 3'd0;
                    cnt_d       = 8'd0;
                    f1_map_d    = 8'h00;
                    f2_map_d    = 8'h00;
                    f3_map_d    = 8'h00;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_code_d = 3'd0;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = 8'd0;
                    f1_map_d = f1_cap;
                    f2_map_d = f2_cap;
                    f3_map_d = f3_cap;
                    if (s_q == 3'd7) begin
                        state_d     = S_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        pass_d      = (map_diff == 8'h00);
                        fail_code_d = first_bad;
                    end else begin
                        s_d = s_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            s_q         <= 3'd0;
            cnt_q       <= 8'd0;
            f1_map_q    <= 8'h00;
            f2_map_q    <= 8'h00;
            f3_map_q    <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            f1_map_q    <= f1_map_d;
            f2_map_q    <= f2_map_d;
            f3_map_q    <= f3_map_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
        end
    end

    assign s         = s_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_code_q;
    assign f1_map    = f1_map_q;
    assign f2_map    = f2_map_q;
    assign f3_map    = f3_map_q;

endmodule

`default_nettype wire
